// File: rtl/iter_mult_acc.sv
// iter_mult_acc: sequential radix-2 shift-add multiplier, p = a*b + c.
// Multiplier bits are consumed one per cycle, LSB first. Valid/ready on both sides.
// Optional running accumulator enabled by defining ITER_MULT_ACC_ACCUM_EN:
// each result then also adds the previous result (total), wrapping at 2*WIDTH bits.
//
// state  | meaning
// IDLE   | in_ready high, waiting for operands
// CALC   | WIDTH shift-add steps, one multiplier bit per cycle
// DONE   | out_valid high, p held until out_ready
module iter_mult_acc #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               c,
   input  logic               acc_clr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] p
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [PW-1:0]    a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [PW-1:0]    acc;
   logic [CW-1:0]    cnt;
   logic [PW-1:0]    acc_nxt;
   logic [PW-1:0]    acc_init;

`ifdef ITER_MULT_ACC_ACCUM_EN
   logic [PW-1:0]    total;
   logic [PW-1:0]    acc_base;

   // clearing on the accept edge makes the new operation start from zero
   always_comb begin
      acc_base = acc_clr ? '0 : total;
      acc_init = {{(PW-1){1'b0}}, c} + acc_base;
   end
`else
   logic unused_acc_clr;
   assign unused_acc_clr = acc_clr;

   // without the accumulator the sum starts from the carry-in alone
   always_comb begin
      acc_init = {{(PW-1){1'b0}}, c};
   end
`endif

   // one shift-add step: add the shifted multiplicand when the current multiplier bit is set
   always_comb begin
      acc_nxt = acc;
      if (b_sh[0]) acc_nxt = acc + a_sh;
   end

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);

   // control FSM and datapath registers; p is loaded on the last CALC edge so it is stable in DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         acc   <= '0;
         cnt   <= '0;
         p     <= '0;
`ifdef ITER_MULT_ACC_ACCUM_EN
         total <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
`ifdef ITER_MULT_ACC_ACCUM_EN
               if (acc_clr) total <= '0;
`endif
               if (in_valid) begin
                  a_sh  <= PW'(a);
                  b_sh  <= b;
                  acc   <= acc_init;
                  cnt   <= '0;
                  state <= S_CALC;
               end
            end
            S_CALC: begin
               acc  <= acc_nxt;
               a_sh <= a_sh << 1;
               b_sh <= b_sh >> 1;
               cnt  <= cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  p     <= acc_nxt;
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state <= S_IDLE;
`ifdef ITER_MULT_ACC_ACCUM_EN
                  total <= acc;
`endif
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iter_mult_acc.sv
// Directed bench for iter_mult_acc: a WIDTH=4 instance for the main scenarios
// and a WIDTH=8 instance for the wide-operand and back-to-back cases.
module tb_iter_mult_acc;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       iv4 = 0, ir4, c4 = 0, clr4 = 0, ov4, or4 = 1;
   logic [3:0] a4 = 0, b4 = 0;
   logic [7:0] p4;

   logic       iv8 = 0, ir8, c8 = 0, clr8 = 0, ov8, or8 = 1;
   logic [7:0] a8 = 0, b8 = 0;
   logic [15:0] p8;

   int checks = 0;
   int failures = 0;

   iter_mult_acc #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .c(c4),
      .acc_clr(clr4), .out_valid(ov4), .out_ready(or4), .p(p4));

   iter_mult_acc #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .c(c8),
      .acc_clr(clr8), .out_valid(ov8), .out_ready(or8), .p(p8));

   // Drives one operation into dut4 from a negedge with the DUT idle; returns at the
   // negedge where out_valid is first seen (lat = edges after accept, -1 on timeout).
   task automatic op4(input logic [3:0] ai, input logic [3:0] bi, input logic ci, input logic cl,
                      output logic [7:0] pr, output int lat, output int busy);
      a4 = ai; b4 = bi; c4 = ci; clr4 = cl; iv4 = 1;
      @(negedge clk);
      iv4 = 0; clr4 = 0;
      lat = -1;
      busy = (ir4 == 1'b0) ? 1 : 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (!ir4) busy++;
         if (ov4) begin lat = n; break; end
      end
      pr = p4;
   endtask

   task automatic test_reset();
      #12;
      checks++; if (ir4 !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", ir4); end
      checks++; if (ov4 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", ov4); end
      checks++; if (p4 !== 8'h00) begin failures++; $display("FAIL reset_p got=%h exp=00", p4); end
      checks++; if (p8 !== 16'h0000) begin failures++; $display("FAIL reset_p8 got=%h exp=0000", p8); end
      @(negedge clk);
      rst = 0;
   endtask

   task automatic test_basic();
      logic [7:0] pr; int lat, busy;
      or4 = 1;
      op4(4'd3, 4'd5, 1'b1, 1'b1, pr, lat, busy);
      checks++; if (pr !== 8'h10) begin failures++; $display("FAIL basic_p got=%h exp=10", pr); end
      checks++; if (lat !== 4) begin failures++; $display("FAIL basic_latency got=%0d exp=4", lat); end
      checks++; if (busy !== 5) begin failures++; $display("FAIL basic_in_ready_low got=%0d exp=5", busy); end
      @(negedge clk);
      checks++; if (ir4 !== 1'b1) begin failures++; $display("FAIL basic_back_idle got=%b exp=1", ir4); end
      checks++; if (ov4 !== 1'b0) begin failures++; $display("FAIL basic_ov_drop got=%b exp=0", ov4); end
   endtask

   task automatic test_values();
      logic [7:0] pr; int lat, busy;
      op4(4'd15, 4'd15, 1'b1, 1'b1, pr, lat, busy);
      checks++; if (pr !== 8'hE2) begin failures++; $display("FAIL max_p got=%h exp=e2", pr); end
      checks++; if (lat !== 4) begin failures++; $display("FAIL max_latency got=%0d exp=4", lat); end
      @(negedge clk);
      op4(4'd9, 4'd0, 1'b1, 1'b1, pr, lat, busy);
      checks++; if (pr !== 8'h01) begin failures++; $display("FAIL bzero_p got=%h exp=01", pr); end
      checks++; if (lat !== 4) begin failures++; $display("FAIL bzero_latency got=%0d exp=4", lat); end
      @(negedge clk);
      op4(4'd15, 4'd1, 1'b0, 1'b1, pr, lat, busy);
      checks++; if (pr !== 8'h0F) begin failures++; $display("FAIL bone_p got=%h exp=0f", pr); end
      @(negedge clk);
      op4(4'd6, 4'd10, 1'b0, 1'b1, pr, lat, busy);
      checks++; if (pr !== 8'h3C) begin failures++; $display("FAIL mix_p got=%h exp=3c", pr); end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      logic [7:0] pr; int lat, busy;
      or4 = 0;
      op4(4'd5, 4'd3, 1'b0, 1'b1, pr, lat, busy);
      checks++; if (pr !== 8'h0F) begin failures++; $display("FAIL bp_p got=%h exp=0f", pr); end
      a4 = 4'd1; b4 = 4'd1; c4 = 1'b1; iv4 = 1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++; if (ov4 !== 1'b1) begin failures++; $display("FAIL bp_hold_valid got=%b exp=1", ov4); end
         checks++; if (p4 !== 8'h0F) begin failures++; $display("FAIL bp_hold_p got=%h exp=0f", p4); end
         checks++; if (ir4 !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", ir4); end
      end
      iv4 = 0; or4 = 1;
      @(negedge clk);
      checks++; if (ov4 !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", ov4); end
      checks++; if (ir4 !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", ir4); end
      checks++; if (p4 !== 8'h0F) begin failures++; $display("FAIL bp_p_retained got=%h exp=0f", p4); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] pr; int lat, busy; int seen;
      or4 = 1;
      a4 = 4'd15; b4 = 4'd15; c4 = 1'b1; iv4 = 1;
      @(negedge clk);
      iv4 = 0;
      @(negedge clk);
      rst = 1;
      #1;
      checks++; if (ir4 !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", ir4); end
      checks++; if (ov4 !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", ov4); end
      checks++; if (p4 !== 8'h00) begin failures++; $display("FAIL rstmid_p got=%h exp=00", p4); end
      @(negedge clk);
      rst = 0;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (ov4) seen = 1;
      end
      checks++; if (seen !== 0) begin failures++; $display("FAIL rstmid_no_pulse got=%0d exp=0", seen); end
      op4(4'd2, 4'd7, 1'b0, 1'b1, pr, lat, busy);
      checks++; if (pr !== 8'h0E) begin failures++; $display("FAIL rstmid_next_p got=%h exp=0e", pr); end
      checks++; if (lat !== 4) begin failures++; $display("FAIL rstmid_next_latency got=%0d exp=4", lat); end
      @(negedge clk);
   endtask

   task automatic test_accum();
      logic [7:0] pr; int lat, busy;
      rst = 1;
      @(negedge clk);
      rst = 0;
      or4 = 1;
      op4(4'd3, 4'd5, 1'b0, 1'b0, pr, lat, busy);
      checks++; if (pr !== 8'd15) begin failures++; $display("FAIL accum_op1 got=%0d exp=15", pr); end
      @(negedge clk);
`ifdef ITER_MULT_ACC_ACCUM_EN
      op4(4'd2, 4'd2, 1'b1, 1'b0, pr, lat, busy);
      checks++; if (pr !== 8'd20) begin failures++; $display("FAIL accum_op2 got=%0d exp=20", pr); end
      @(negedge clk);
      op4(4'd1, 4'd1, 1'b0, 1'b1, pr, lat, busy);
      checks++; if (pr !== 8'd1) begin failures++; $display("FAIL accum_clr got=%0d exp=1", pr); end
      @(negedge clk);
      op4(4'd15, 4'd15, 1'b1, 1'b0, pr, lat, busy);
      checks++; if (pr !== 8'd227) begin failures++; $display("FAIL accum_big got=%0d exp=227", pr); end
      @(negedge clk);
      op4(4'd15, 4'd15, 1'b1, 1'b0, pr, lat, busy);
      checks++; if (pr !== 8'd197) begin failures++; $display("FAIL accum_wrap got=%0d exp=197", pr); end
      @(negedge clk);
`else
      op4(4'd2, 4'd2, 1'b1, 1'b0, pr, lat, busy);
      checks++; if (pr !== 8'd5) begin failures++; $display("FAIL noaccum_op2 got=%0d exp=5", pr); end
      @(negedge clk);
      op4(4'd1, 4'd1, 1'b0, 1'b1, pr, lat, busy);
      checks++; if (pr !== 8'd1) begin failures++; $display("FAIL noaccum_clr got=%0d exp=1", pr); end
      @(negedge clk);
`endif
   endtask

   task automatic test_width8();
      int lat;
      or8 = 1;
      a8 = 8'd255; b8 = 8'd255; c8 = 1'b1; clr8 = 1'b1; iv8 = 1;
      @(negedge clk);
      iv8 = 0; clr8 = 0;
      lat = -1;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (ov8) begin lat = n; break; end
      end
      checks++; if (p8 !== 16'hFE02) begin failures++; $display("FAIL w8_p got=%h exp=fe02", p8); end
      checks++; if (lat !== 8) begin failures++; $display("FAIL w8_latency got=%0d exp=8", lat); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int t0, t1; logic prev; logic [15:0] pv0, pv1;
      t0 = -1; t1 = -1; prev = 1'b0; pv0 = '0; pv1 = '0;
      or8 = 1;
      a8 = 8'd3; b8 = 8'd4; c8 = 1'b1; clr8 = 1'b1; iv8 = 1;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         if (ov8 && !prev) begin
            if (t0 < 0) begin t0 = n; pv0 = p8; end
            else if (t1 < 0) begin t1 = n; pv1 = p8; end
         end
         prev = ov8;
         if (t1 >= 0) break;
      end
      iv8 = 0; clr8 = 0;
      checks++; if ((t1 - t0) !== 10) begin failures++; $display("FAIL b2b_interval got=%0d exp=10", t1 - t0); end
      checks++; if (pv0 !== 16'd13) begin failures++; $display("FAIL b2b_p0 got=%0d exp=13", pv0); end
      checks++; if (pv1 !== 16'd13) begin failures++; $display("FAIL b2b_p1 got=%0d exp=13", pv1); end
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_values();
      test_backpressure();
      test_reset_mid();
      test_accum();
      test_width8();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
